// File: rtl/tx_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tx_sched_pkg
// Description : Shared types and constants for the transmit scheduler:
//               FSM state encoding, mux source encodings and the bit
//               counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package tx_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEL   = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } tx_state_t;

    // Source encodings double as the transmit-mux select values.
    localparam logic SRC_MEM = 1'b0;
    localparam logic SRC_CAT = 1'b1;

    // Bit counter width: wide enough to hold DATA_W (the frame length minus
    // one when a parity bit is appended).
    function automatic int tx_cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_sched_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tx_rr_arb
// Description : Two-way round-robin arbiter between the concat and memory
//               sources. Grant is combinational from the requests and the
//               priority pointer; the pointer moves away from the granted
//               source only when i_update is strobed.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_rr_arb
    import tx_sched_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_cat,
    input  logic i_req_mem,
    input  logic i_update,
    output logic o_grant,
    output logic o_grant_valid
);

    // 1: concat wins a tie, 0: memory wins a tie.
    logic r_prio_cat;

    // Grant selection: a lone request always wins, a tie follows the pointer.
    always_comb begin
        o_grant_valid = i_req_cat | i_req_mem;
        o_grant       = SRC_MEM;
        if (i_req_cat && i_req_mem) begin
            o_grant = r_prio_cat ? SRC_CAT : SRC_MEM;
        end else if (i_req_cat) begin
            o_grant = SRC_CAT;
        end
    end

    // Pointer register: favour the other source after a completed grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio_cat <= 1'b1;
        end else if (i_update && o_grant_valid) begin
            r_prio_cat <= (o_grant == SRC_MEM);
        end
    end

endmodule
`default_nettype wire

// File: rtl/tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tx_sched
// Description : Transmit scheduler. Round-robin arbitrates the concat and
//               memory word sources, drives the transmit mux select, captures
//               the mux output and shifts it out LSB-first with a framing
//               strobe and a done pulse.
//               Optional feature macro: TX_SCHED_PARITY_EN appends an
//               even-parity bit after the MSB (frame length DATA_W+1).
// Revision    : 1.0 - initial release
// ============================================================================
module tx_sched
    import tx_sched_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cat_req,
    output logic              o_cat_ack,
    input  logic              i_mem_req,
    output logic              o_mem_ack,
    output logic              o_ctrl_mode,
    input  logic [DATA_W-1:0] i_tx_din,
    output logic              o_tx_sdo,
    output logic              o_tx_frame,
    output logic              o_tx_done,
    output logic              o_tx_busy
);

`ifdef TX_SCHED_PARITY_EN
    localparam int FRAME_W = DATA_W + 1;
`else
    localparam int FRAME_W = DATA_W;
`endif
    localparam int             CNT_W    = tx_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    tx_state_t          r_state;
    tx_state_t          w_next;

    logic               r_mode;
    logic               r_cat_ack;
    logic               r_mem_ack;
    logic               r_sdo;
    logic               r_frame;
    logic               r_done;
    logic               r_busy;
    logic [FRAME_W-1:0] r_sr;
    logic [CNT_W-1:0]   r_cnt;

    logic [FRAME_W-1:0] w_frame_data;
    logic               w_arb_cat;
    logic               w_arb_mem;
    logic               w_gnt;
    logic               w_gnt_vld;
    logic               w_req_granted;
    logic               w_arb_update;

    // Word as it will appear on the line, parity bit on top when enabled.
`ifdef TX_SCHED_PARITY_EN
    assign w_frame_data = {^i_tx_din, i_tx_din};
`else
    assign w_frame_data = i_tx_din;
`endif

    // Outside IDLE the arbiter only sees the source already granted, so the
    // pointer update in LOAD always follows the word actually captured even
    // if the other source raises its request meanwhile.
    assign w_arb_cat     = (r_state == S_IDLE) ? i_cat_req : (r_mode == SRC_CAT);
    assign w_arb_mem     = (r_state == S_IDLE) ? i_mem_req : (r_mode == SRC_MEM);
    assign w_arb_update  = (r_state == S_LOAD);
    assign w_req_granted = (r_mode == SRC_CAT) ? i_cat_req : i_mem_req;

    tx_rr_arb u_arb (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_cat     (w_arb_cat),
        .i_req_mem     (w_arb_mem),
        .i_update      (w_arb_update),
        .o_grant       (w_gnt),
        .o_grant_valid (w_gnt_vld)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_gnt_vld) w_next = S_SEL;
            S_SEL:   w_next = w_req_granted ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == CNT_ZERO) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Registered outputs and datapath: mux select, capture, shifter, strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= SRC_MEM;
            r_cat_ack <= 1'b0;
            r_mem_ack <= 1'b0;
            r_sdo     <= 1'b0;
            r_frame   <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_sr      <= '0;
            r_cnt     <= CNT_ZERO;
        end else begin
            r_cat_ack <= 1'b0;
            r_mem_ack <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_mode <= w_gnt;
                    end
                end
                S_LOAD: begin
                    // Bit 0 goes straight to the line; the rest wait in r_sr.
                    r_sdo     <= w_frame_data[0];
                    r_sr      <= {1'b0, w_frame_data[FRAME_W-1:1]};
                    r_frame   <= 1'b1;
                    r_cnt     <= CNT_LAST;
                    r_cat_ack <= (r_mode == SRC_CAT);
                    r_mem_ack <= (r_mode == SRC_MEM);
                end
                S_SHIFT: begin
                    if (r_cnt != CNT_ZERO) begin
                        r_sdo <= r_sr[0];
                        r_sr  <= {1'b0, r_sr[FRAME_W-1:1]};
                        r_cnt <= r_cnt - CNT_ONE;
                    end else begin
                        r_sdo   <= 1'b0;
                        r_frame <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_ctrl_mode = r_mode;
    assign o_cat_ack   = r_cat_ack;
    assign o_mem_ack   = r_mem_ack;
    assign o_tx_sdo    = r_sdo;
    assign o_tx_frame  = r_frame;
    assign o_tx_done   = r_done;
    assign o_tx_busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_sched
// Description : Directed self-checking bench for tx_sched. The bench models
//               the 2:1 transmit mux from o_ctrl_mode and records the serial
//               stream, acks and done pulses with a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_sched;

    localparam int DATA_W = 32;
`ifdef TX_SCHED_PARITY_EN
    localparam int N = DATA_W + 1;
`else
    localparam int N = DATA_W;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cat_req = 1'b0;
    logic              mem_req = 1'b0;
    logic [DATA_W-1:0] cat_word = '0;
    logic [DATA_W-1:0] mem_word = '0;
    logic [DATA_W-1:0] tx_din;
    logic cat_ack, mem_ack, ctrl_mode, tx_sdo, tx_frame, tx_done, tx_busy;

    int checks = 0;
    int errors = 0;

    // Transmit mux in front of the scheduler.
    assign tx_din = ctrl_mode ? cat_word : mem_word;

    tx_sched #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cat_req   (cat_req),
        .o_cat_ack   (cat_ack),
        .i_mem_req   (mem_req),
        .o_mem_ack   (mem_ack),
        .o_ctrl_mode (ctrl_mode),
        .i_tx_din    (tx_din),
        .o_tx_sdo    (tx_sdo),
        .o_tx_frame  (tx_frame),
        .o_tx_done   (tx_done),
        .o_tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    // ---------------- monitor ----------------
    logic [63:0] m_bits;
    int m_cur, m_gap, m_frames, m_dones, m_done_bad, m_cat_acks, m_mem_acks;
    logic m_prev_frame;
    int m_order[$];
    int m_gaps[$];
    int m_lens[$];

    task automatic clear_mon();
        m_bits = '0; m_cur = 0; m_gap = 0; m_frames = 0; m_dones = 0;
        m_done_bad = 0; m_cat_acks = 0; m_mem_acks = 0; m_prev_frame = 1'b0;
        m_order.delete(); m_gaps.delete(); m_lens.delete();
    endtask

    always @(negedge clk) begin
        if (cat_ack) begin m_cat_acks++; m_order.push_back(1); end
        if (mem_ack) begin m_mem_acks++; m_order.push_back(0); end
        if (tx_done) begin
            m_dones++;
            if (!m_prev_frame || tx_frame) m_done_bad++;
        end
        if (tx_frame) begin
            if (!m_prev_frame) begin
                if (m_frames > 0) m_gaps.push_back(m_gap);
                m_frames++;
                m_cur = 0;
                m_bits = '0;
            end
            if (m_cur < 64) m_bits[m_cur] = tx_sdo;
            m_cur++;
            m_gap = 0;
        end else begin
            if (m_prev_frame) m_lens.push_back(m_cur);
            m_gap++;
        end
        m_prev_frame = tx_frame;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int max_cycles);
        int i;
        i = 0;
        while (tx_done !== 1'b1 && i < max_cycles) begin
            tick();
            i++;
        end
    endtask

    function automatic logic [N-1:0] frame_of(input logic [DATA_W-1:0] d);
`ifdef TX_SCHED_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({ctrl_mode, tx_sdo, tx_frame, tx_done, cat_ack, mem_ack, tx_busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {ctrl_mode, tx_sdo, tx_frame, tx_done, cat_ack, mem_ack, tx_busy});
        end
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if ({tx_frame, tx_busy, cat_ack, mem_ack} !== 4'b0) begin
            errors++;
            $display("FAIL idle_quiet: got %b expected 0000", {tx_frame, tx_busy, cat_ack, mem_ack});
        end
    endtask

    task automatic test_single_cat();
        clear_mon();
        cat_word = 32'h0000_00FF;
        cat_req  = 1'b1;
        tick();                                  // sampled in IDLE -> SEL
        checks++;
        if (ctrl_mode !== 1'b1 || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL cat_sel: mode=%b busy=%b expected 1 1", ctrl_mode, tx_busy);
        end
        tick();                                  // LOAD
        checks++;
        if (cat_ack !== 1'b0 || tx_frame !== 1'b0) begin
            errors++;
            $display("FAIL cat_load: ack=%b frame=%b expected 0 0", cat_ack, tx_frame);
        end
        tick();                                  // first bit
        checks++;
        if (cat_ack !== 1'b1 || tx_frame !== 1'b1 || tx_sdo !== 1'b1) begin
            errors++;
            $display("FAIL cat_first_bit: ack=%b frame=%b sdo=%b expected 1 1 1", cat_ack, tx_frame, tx_sdo);
        end
        cat_req = 1'b0;
        wait_done(N + 5);
        checks++;
        if (tx_done !== 1'b1 || tx_frame !== 1'b0) begin
            errors++;
            $display("FAIL cat_done: done=%b frame=%b expected 1 0", tx_done, tx_frame);
        end
        tick();
        checks++;
        if (tx_done !== 1'b0 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL cat_done_pulse: done=%b busy=%b expected 0 0", tx_done, tx_busy);
        end
        checks++;
        if (m_lens.size() != 1 || m_lens[0] != N) begin
            errors++;
            $display("FAIL cat_frame_len: got %0d frames, len %0d expected 1 frame len %0d",
                     m_lens.size(), (m_lens.size() > 0) ? m_lens[0] : -1, N);
        end
        checks++;
        if (m_bits[N-1:0] !== frame_of(32'h0000_00FF)) begin
            errors++;
            $display("FAIL cat_bits: got %h expected %h", m_bits[N-1:0], frame_of(32'h0000_00FF));
        end
        checks++;
        if (m_cat_acks != 1 || m_mem_acks != 0 || m_dones != 1 || m_done_bad != 0) begin
            errors++;
            $display("FAIL cat_pulses: cat_ack=%0d mem_ack=%0d done=%0d bad_done=%0d expected 1 0 1 0",
                     m_cat_acks, m_mem_acks, m_dones, m_done_bad);
        end
    endtask

    task automatic test_single_mem();
        clear_mon();
        mem_word = 32'h0000_0011;
        mem_req  = 1'b1;
        tick();
        checks++;
        if (ctrl_mode !== 1'b0) begin
            errors++;
            $display("FAIL mem_sel: mode=%b expected 0", ctrl_mode);
        end
        tick(); tick();
        checks++;
        if (mem_ack !== 1'b1 || cat_ack !== 1'b0 || tx_sdo !== 1'b1) begin
            errors++;
            $display("FAIL mem_ack: mem_ack=%b cat_ack=%b sdo=%b expected 1 0 1", mem_ack, cat_ack, tx_sdo);
        end
        mem_req = 1'b0;
        wait_done(N + 5);
        tick();
        checks++;
        if (m_bits[N-1:0] !== frame_of(32'h0000_0011)) begin
            errors++;
            $display("FAIL mem_bits: got %h expected %h", m_bits[N-1:0], frame_of(32'h0000_0011));
        end
        checks++;
        if (m_cat_acks != 0 || m_mem_acks != 1 || m_dones != 1) begin
            errors++;
            $display("FAIL mem_pulses: cat_ack=%0d mem_ack=%0d done=%0d expected 0 1 1",
                     m_cat_acks, m_mem_acks, m_dones);
        end
    endtask

    task automatic test_back_to_back();
        int i;
        clear_mon();
        cat_word = 32'hA5A5_0F0F;
        mem_word = 32'h1234_5678;
        cat_req  = 1'b1;
        mem_req  = 1'b1;
        i = 0;
        while (m_dones < 3 && i < 4 * (N + 4) + 20) begin
            tick();
            i++;
        end
        cat_req = 1'b0;
        mem_req = 1'b0;
        tick(); tick();
        checks++;
        if (m_dones != 3) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d expected 3", m_dones);
        end
        checks++;
        if (m_order.size() != 3 || m_order[0] != 1 || m_order[1] != 0 || m_order[2] != 1) begin
            errors++;
            $display("FAIL b2b_order: got %0d grants first=%0d expected 3 grants cat,mem,cat",
                     m_order.size(), (m_order.size() > 0) ? m_order[0] : -1);
        end
        checks++;
        if (m_gaps.size() != 2 || m_gaps[0] != 4 || m_gaps[1] != 4) begin
            errors++;
            $display("FAIL b2b_gap: got %0d gaps first=%0d expected 2 gaps of 4",
                     m_gaps.size(), (m_gaps.size() > 0) ? m_gaps[0] : -1);
        end
        checks++;
        if (m_lens.size() != 3 || m_lens[0] != N || m_lens[1] != N || m_lens[2] != N) begin
            errors++;
            $display("FAIL b2b_len: got %0d frames expected 3 frames of %0d", m_lens.size(), N);
        end
        checks++;
        if (m_bits[N-1:0] !== frame_of(32'hA5A5_0F0F)) begin
            errors++;
            $display("FAIL b2b_last_bits: got %h expected %h", m_bits[N-1:0], frame_of(32'hA5A5_0F0F));
        end
    endtask

    task automatic test_abort_sel();
        clear_mon();
        cat_word = 32'hDEAD_BEEF;
        cat_req  = 1'b1;
        tick();                                  // SEL, concat granted
        checks++;
        if (ctrl_mode !== 1'b1) begin
            errors++;
            $display("FAIL abort_grant: mode=%b expected 1", ctrl_mode);
        end
        cat_req = 1'b0;
        tick();                                  // back in IDLE
        checks++;
        if (tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b expected 0", tx_busy);
        end
        repeat (4) tick();
        checks++;
        if (m_cat_acks != 0 || m_frames != 0 || m_dones != 0 || ctrl_mode !== 1'b1) begin
            errors++;
            $display("FAIL abort_quiet: acks=%0d frames=%0d dones=%0d mode=%b expected 0 0 0 1",
                     m_cat_acks, m_frames, m_dones, ctrl_mode);
        end
        mem_word = 32'h0000_8001;
        mem_req  = 1'b1;
        tick();
        checks++;
        if (ctrl_mode !== 1'b0) begin
            errors++;
            $display("FAIL abort_mem_sel: mode=%b expected 0", ctrl_mode);
        end
        tick(); tick();
        checks++;
        if (mem_ack !== 1'b1) begin
            errors++;
            $display("FAIL abort_mem_ack: got %b expected 1", mem_ack);
        end
        mem_req = 1'b0;
        wait_done(N + 5);
        tick();
        checks++;
        if (m_bits[N-1:0] !== frame_of(32'h0000_8001) || m_dones != 1) begin
            errors++;
            $display("FAIL abort_mem_frame: bits=%h dones=%0d expected %h 1",
                     m_bits[N-1:0], m_dones, frame_of(32'h0000_8001));
        end
    endtask

    task automatic test_word7();
        clear_mon();
        cat_word = 32'h0000_0007;
        cat_req  = 1'b1;
        tick(); tick(); tick();
        cat_req = 1'b0;
        wait_done(N + 5);
        tick();
        checks++;
        if (m_lens.size() != 1 || m_lens[0] != N) begin
            errors++;
            $display("FAIL w7_len: frames=%0d expected 1 of %0d", m_lens.size(), N);
        end
        checks++;
`ifdef TX_SCHED_PARITY_EN
        if (m_bits[N-1:0] !== 33'h1_0000_0007) begin
            errors++;
            $display("FAIL w7_bits: got %h expected 100000007", m_bits[N-1:0]);
        end
`else
        if (m_bits[N-1:0] !== 32'h0000_0007) begin
            errors++;
            $display("FAIL w7_bits: got %h expected 00000007", m_bits[N-1:0]);
        end
`endif
    endtask

    task automatic test_reset_mid_shift();
        clear_mon();
        cat_word = 32'hFFFF_FFFF;
        cat_req  = 1'b1;
        tick(); tick(); tick();                  // bit 0 on the line
        cat_req = 1'b0;
        repeat (10) tick();                      // bit 10 on the line
        checks++;
        if (tx_frame !== 1'b1 || tx_sdo !== 1'b1 || ctrl_mode !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: frame=%b sdo=%b mode=%b expected 1 1 1", tx_frame, tx_sdo, ctrl_mode);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({ctrl_mode, tx_sdo, tx_frame, tx_done, cat_ack, mem_ack, tx_busy} !== 7'b0) begin
            errors++;
            $display("FAIL rst_async: got %b expected 0000000",
                     {ctrl_mode, tx_sdo, tx_frame, tx_done, cat_ack, mem_ack, tx_busy});
        end
        clear_mon();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (m_dones != 0 || m_cat_acks != 0 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_done: dones=%0d acks=%0d busy=%b expected 0 0 0", m_dones, m_cat_acks, tx_busy);
        end
        cat_word = 32'h0000_00F0;
        cat_req  = 1'b1;
        mem_req  = 1'b1;
        tick();
        checks++;
        if (ctrl_mode !== 1'b1) begin
            errors++;
            $display("FAIL rst_tie_grant: mode=%b expected 1", ctrl_mode);
        end
        tick(); tick();
        checks++;
        if (cat_ack !== 1'b1 || mem_ack !== 1'b0) begin
            errors++;
            $display("FAIL rst_tie_ack: cat_ack=%b mem_ack=%b expected 1 0", cat_ack, mem_ack);
        end
        cat_req = 1'b0;
        mem_req = 1'b0;
        wait_done(N + 5);
        tick();
        checks++;
        if (m_bits[N-1:0] !== frame_of(32'h0000_00F0) || m_dones != 1) begin
            errors++;
            $display("FAIL rst_tie_frame: bits=%h dones=%0d expected %h 1",
                     m_bits[N-1:0], m_dones, frame_of(32'h0000_00F0));
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_single_cat();
        test_single_mem();
        test_back_to_back();
        test_abort_sel();
        test_word7();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
